fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// Burst reader: pops a requested number of words from a FIFO read port
// and presents them on a valid/ready output with zero-bubble throughput.
module fifo_reader #(
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic          i_abort,
    output logic          o_fifo_rd,
    input  logic          i_fifo_empty,
    input  logic [DW-1:0] i_fifo_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [LW-1:0] o_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [LW-1:0] r_rem;
    logic [LW-1:0] r_count;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_pop;
    logic          w_acc;
    logic          w_abort;
    logic          w_launch;

    assign w_abort  = i_abort && (r_state != S_IDLE);
    assign w_launch = (r_state == S_IDLE) && i_start;
    assign w_acc    = r_valid && i_ready;

    // Reset and abort both gate the strobe so the FIFO never loses a word.
    assign w_pop = i_rstn && !w_abort && (r_state == S_RUN) &&
                   (r_rem != '0) && !i_fifo_empty &&
                   (!r_valid || i_ready);

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_next = (i_len != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_pop && (r_rem == LW'(1))) begin
                        w_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_valid || i_ready) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_count <= '0;
            end else if (w_acc) begin
                r_count <= r_count + 1'b1;
            end
            if (w_abort) begin
                r_valid <= 1'b0;
                r_rem   <= '0;
            end else if (w_pop) begin
                r_data  <= i_fifo_data;
                r_valid <= 1'b1;
                r_rem   <= r_rem - 1'b1;
            end else begin
                if (w_acc) begin
                    r_valid <= 1'b0;
                end
                if (w_launch) begin
                    r_rem <= i_len;
                end
            end
        end
    end

    assign o_fifo_rd = w_pop;
    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_count   = r_count;
    assign o_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done    = (r_state == S_DONE);

endmodule
